// File: rtl/fifo_sync_if.sv
// fifo_sync_if -- handshake/status bundle for fifo_sync.
//
// Groups the push, pop, flush and status signals of one FIFO instance.
//   master : the client side. Drives i_flush, i_wr_en, i_wr_data and i_rd_en.
//            Observes o_rd_data, o_rd_valid, o_full, o_empty, o_almost_full,
//            o_almost_empty and o_count.
//   slave  : the FIFO side, with the directions reversed.
//
// Optional error reporting: when FIFO_SYNC_ERR_EN is defined, the bundle also
// carries i_err_clr (client -> FIFO), o_overflow and o_underflow
// (FIFO -> client).
//
// DataWidth and Depth must match the fifo_sync instance that uses this bundle.
// o_count is $clog2(Depth+1) bits wide.
interface fifo_sync_if #(
  parameter int DataWidth = 8,
  parameter int Depth     = 8
);
  localparam int CntWidth = $clog2(Depth + 1);

  logic                 i_flush;
  logic                 i_wr_en;
  logic [DataWidth-1:0] i_wr_data;
  logic                 i_rd_en;
  logic [DataWidth-1:0] o_rd_data;
  logic                 o_rd_valid;
  logic                 o_full;
  logic                 o_empty;
  logic                 o_almost_full;
  logic                 o_almost_empty;
  logic [CntWidth-1:0]  o_count;

`ifdef FIFO_SYNC_ERR_EN
  logic                 i_err_clr;
  logic                 o_overflow;
  logic                 o_underflow;

  modport master (
    output i_flush, i_wr_en, i_wr_data, i_rd_en, i_err_clr,
    input  o_rd_data, o_rd_valid, o_full, o_empty, o_almost_full,
           o_almost_empty, o_count, o_overflow, o_underflow
  );

  modport slave (
    input  i_flush, i_wr_en, i_wr_data, i_rd_en, i_err_clr,
    output o_rd_data, o_rd_valid, o_full, o_empty, o_almost_full,
           o_almost_empty, o_count, o_overflow, o_underflow
  );
`else
  modport master (
    output i_flush, i_wr_en, i_wr_data, i_rd_en,
    input  o_rd_data, o_rd_valid, o_full, o_empty, o_almost_full,
           o_almost_empty, o_count
  );

  modport slave (
    input  i_flush, i_wr_en, i_wr_data, i_rd_en,
    output o_rd_data, o_rd_valid, o_full, o_empty, o_almost_full,
           o_almost_empty, o_count
  );
`endif
endinterface

// File: rtl/fifo_sync.sv
// fifo_sync -- single-clock FIFO with integrated storage.
//
// Buffers bytes between the UART engines and the host register interface.
//
// Features:
//   - Depth may be any value >= 2; it does not have to be a power of two.
//   - Push and pop requests are guarded: a push while full and a pop while
//     empty are dropped.
//   - Read data is registered. o_rd_valid pulses for one cycle, one cycle
//     after each accepted pop.
//   - Occupancy count, plus almost-full and almost-empty flags.
//   - Synchronous flush.
//
// Ports:
//   i_clk    rising-edge clock
//   i_rst_n  asynchronous active-low reset
//   bus      fifo_sync_if.slave. It carries:
//              i_flush, i_wr_en, i_wr_data, i_rd_en
//              o_rd_data, o_rd_valid, o_full, o_empty
//              o_almost_full, o_almost_empty, o_count
//
// Optional feature, enabled by defining FIFO_SYNC_ERR_EN:
//   - Sticky o_overflow and o_underflow flags.
//   - i_err_clr clears both flags. If a flag is set and cleared in the same
//     cycle, the set takes priority.
module fifo_sync #(
  parameter int DataWidth      = 8,
  parameter int Depth          = 8,
  parameter int AlmostFullThr  = 6,
  parameter int AlmostEmptyThr = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  fifo_sync_if.slave bus
);
  localparam int PtrWidth = $clog2(Depth);
  localparam int CntWidth = $clog2(Depth + 1);
  localparam logic [PtrWidth-1:0] LastPtr  = PtrWidth'(Depth - 1);
  localparam logic [CntWidth-1:0] DepthCnt = CntWidth'(Depth);
  localparam logic [CntWidth-1:0] AfThr    = CntWidth'(AlmostFullThr);
  localparam logic [CntWidth-1:0] AeThr    = CntWidth'(AlmostEmptyThr);

  // Storage is deliberately left without a reset so it maps to block RAM.
  logic [DataWidth-1:0] mem [Depth];

  logic [PtrWidth-1:0]  wr_ptr_reg, wr_ptr_next;
  logic [PtrWidth-1:0]  rd_ptr_reg, rd_ptr_next;
  logic [CntWidth-1:0]  count_reg, count_next;
  logic [DataWidth-1:0] rd_data_reg;
  logic                 rd_valid_reg;
  logic                 full, empty;
  logic                 push_ok, pop_ok;

  assign full  = (count_reg == DepthCnt);
  assign empty = (count_reg == '0);

  // The full and empty flags come from the count before this cycle's update.
  // So when the FIFO is full and both requests arrive, only the pop is
  // accepted. When it is empty and both arrive, only the push is accepted.
  // A flush drops both requests.
  assign push_ok = bus.i_wr_en & ~full  & ~bus.i_flush;
  assign pop_ok  = bus.i_rd_en & ~empty & ~bus.i_flush;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (bus.i_flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      // Pointers wrap by explicit compare, because Depth may not be a
      // power of two.
      if (push_ok) begin
        wr_ptr_next = (wr_ptr_reg == LastPtr) ? '0 : wr_ptr_reg + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_next = (rd_ptr_reg == LastPtr) ? '0 : rd_ptr_reg + 1'b1;
      end
      count_next = count_reg + CntWidth'(push_ok) - CntWidth'(pop_ok);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      rd_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      // pop_ok is already gated by flush, so a flush also clears the
      // valid strobe. The read data holds its last value.
      rd_valid_reg <= pop_ok;
      if (pop_ok) begin
        rd_data_reg <= mem[rd_ptr_reg];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= bus.i_wr_data;
    end
  end

  assign bus.o_rd_data      = rd_data_reg;
  assign bus.o_rd_valid     = rd_valid_reg;
  assign bus.o_full         = full;
  assign bus.o_empty        = empty;
  assign bus.o_almost_full  = (count_reg >= AfThr);
  assign bus.o_almost_empty = (count_reg <= AeThr);
  assign bus.o_count        = count_reg;

`ifdef FIFO_SYNC_ERR_EN
  logic overflow_reg;
  logic underflow_reg;

  // The error flags are not affected by flush. A set in the same cycle as
  // i_err_clr wins.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (bus.i_wr_en & full & ~bus.i_flush) begin
        overflow_reg <= 1'b1;
      end else if (bus.i_err_clr) begin
        overflow_reg <= 1'b0;
      end
      if (bus.i_rd_en & empty & ~bus.i_flush) begin
        underflow_reg <= 1'b1;
      end else if (bus.i_err_clr) begin
        underflow_reg <= 1'b0;
      end
    end
  end

  assign bus.o_overflow  = overflow_reg;
  assign bus.o_underflow = underflow_reg;
`endif
endmodule

// File: tb/tb_fifo_sync.sv
// tb_fifo_sync -- self-checking bench for fifo_sync.
// Configuration: Depth=5, AlmostFullThr=4, AlmostEmptyThr=2.
// A reference queue model tracks the FIFO contents. Each accepted pop pushes
// its expected word onto a scoreboard queue, which is popped and compared
// when the DUT presents read data. Inputs are driven on the falling edge, and
// outputs are sampled on the following falling edge.
module tb_fifo_sync;
  localparam int DW    = 8;
  localparam int DEPTH = 5;
  localparam int AF    = 4;
  localparam int AE    = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_sync_if #(.DataWidth(DW), .Depth(DEPTH)) bus ();

  fifo_sync #(
    .DataWidth(DW), .Depth(DEPTH), .AlmostFullThr(AF), .AlmostEmptyThr(AE)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  int            n_cmp = 0;
  int            n_err = 0;
  logic [DW-1:0] mdl[$];
  logic [DW-1:0] sb_q[$];
  bit            exp_valid = 1'b0;
  logic [DW-1:0] exp_hold  = '0;
  bit            exp_ovf   = 1'b0;
  bit            exp_udf   = 1'b0;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  // Drives one cycle of stimulus, updates the reference model, and returns at
  // the next falling edge.
  task automatic step(input bit wr, input logic [DW-1:0] wd, input bit rd,
                      input bit fl, input bit ec);
    bit full_m, empty_m, push_m, pop_m;
    bus.i_wr_en   = wr;
    bus.i_wr_data = wd;
    bus.i_rd_en   = rd;
    bus.i_flush   = fl;
`ifdef FIFO_SYNC_ERR_EN
    bus.i_err_clr = ec;
`endif
    full_m  = (mdl.size() == DEPTH);
    empty_m = (mdl.size() == 0);
    push_m  = wr && !full_m && !fl;
    pop_m   = rd && !empty_m && !fl;
    if (!fl && wr && full_m) exp_ovf = 1'b1;
    else if (ec)             exp_ovf = 1'b0;
    if (!fl && rd && empty_m) exp_udf = 1'b1;
    else if (ec)              exp_udf = 1'b0;
    if (fl) mdl.delete();
    if (pop_m) begin
      exp_hold = mdl.pop_front();
      sb_q.push_back(exp_hold);
    end
    if (push_m) mdl.push_back(wd);
    exp_valid = pop_m;
    $display("t=%0t wr=%0b wd=%02h rd=%0b flush=%0b clr=%0b push_ok=%0b pop_ok=%0b occ=%0d",
             $time, wr, wd, rd, fl, ec, push_m, pop_m, mdl.size());
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.i_wr_en = 0; bus.i_wr_data = '0; bus.i_rd_en = 0; bus.i_flush = 0;
`ifdef FIFO_SYNC_ERR_EN
    bus.i_err_clr = 0;
`endif
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({bus.o_count, bus.o_empty, bus.o_full, bus.o_almost_empty, bus.o_almost_full}
        !== {CW'(0), 1'b1, 1'b0, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL reset_flags: count=%0d e/f/ae/af=%b%b%b%b, required 0 1010",
               bus.o_count, bus.o_empty, bus.o_full, bus.o_almost_empty, bus.o_almost_full);
    end
    n_cmp++;
    if ({bus.o_rd_valid, bus.o_rd_data} !== {1'b0, 8'h00}) begin
      n_err++;
      $display("FAIL reset_rd: valid=%0b data=%02h, required 0/00", bus.o_rd_valid, bus.o_rd_data);
    end
`ifdef FIFO_SYNC_ERR_EN
    n_cmp++;
    if ({bus.o_overflow, bus.o_underflow} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_err: ovf/udf=%b%b, required 00", bus.o_overflow, bus.o_underflow);
    end
`endif
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      step(1, 8'h11 + 8'(i), 0, 0, 0);
      n_cmp++;
      if ({bus.o_count, bus.o_almost_full, bus.o_full, bus.o_empty, bus.o_almost_empty}
          !== {CW'(i + 1), (i + 1) >= AF, (i + 1) == DEPTH, 1'b0, (i + 1) <= AE}) begin
        n_err++;
        $display("FAIL fill_%0d: count=%0d af/f/e/ae=%b%b%b%b, required count=%0d af=%0b f=%0b ae=%0b",
                 i, bus.o_count, bus.o_almost_full, bus.o_full, bus.o_empty, bus.o_almost_empty,
                 i + 1, (i + 1) >= AF, (i + 1) == DEPTH, (i + 1) <= AE);
      end
    end
  endtask

  task automatic test_drain();
    logic [DW-1:0] d;
    for (int i = 0; i < DEPTH; i++) begin
      step(0, '0, 1, 0, 0);
      if (exp_valid) begin
        d = sb_q.pop_front();
        n_cmp++;
        if (bus.o_rd_valid !== 1'b1 || bus.o_rd_data !== d) begin
          n_err++;
          $display("FAIL drain_rd_%0d: valid=%0b data=%02h, required 1/%02h",
                   i, bus.o_rd_valid, bus.o_rd_data, d);
        end
      end
      n_cmp++;
      if (bus.o_count !== CW'(DEPTH - 1 - i)) begin
        n_err++;
        $display("FAIL drain_count_%0d: count=%0d, required %0d", i, bus.o_count, DEPTH - 1 - i);
      end
    end
    n_cmp++;
    if (bus.o_empty !== 1'b1) begin
      n_err++;
      $display("FAIL drain_empty: empty=%0b, required 1", bus.o_empty);
    end
    step(0, '0, 0, 0, 0);
    n_cmp++;
    if (bus.o_rd_valid !== 1'b0 || bus.o_rd_data !== exp_hold) begin
      n_err++;
      $display("FAIL drain_hold: valid=%0b data=%02h, required 0/%02h",
               bus.o_rd_valid, bus.o_rd_data, exp_hold);
    end
  endtask

  task automatic test_full_both();
    logic [DW-1:0] d;
    for (int i = 0; i < DEPTH; i++) step(1, 8'h11 + 8'(i), 0, 0, 0);
    step(1, 8'hAA, 1, 0, 0);
    d = sb_q.pop_front();
    n_cmp++;
    if (bus.o_rd_valid !== 1'b1 || bus.o_rd_data !== d || bus.o_count !== CW'(DEPTH - 1)) begin
      n_err++;
      $display("FAIL full_both: valid=%0b data=%02h count=%0d, required 1/%02h/%0d",
               bus.o_rd_valid, bus.o_rd_data, bus.o_count, d, DEPTH - 1);
    end
`ifdef FIFO_SYNC_ERR_EN
    n_cmp++;
    if (bus.o_overflow !== exp_ovf) begin
      n_err++;
      $display("FAIL overflow_set: ovf=%0b, required %0b", bus.o_overflow, exp_ovf);
    end
    step(0, '0, 0, 0, 1);
    n_cmp++;
    if (bus.o_overflow !== exp_ovf) begin
      n_err++;
      $display("FAIL overflow_clr: ovf=%0b, required %0b", bus.o_overflow, exp_ovf);
    end
    step(0, '0, 0, 0, 0);
`endif
    while (mdl.size() > 0) begin
      step(0, '0, 1, 0, 0);
      d = sb_q.pop_front();
      n_cmp++;
      if (bus.o_rd_valid !== 1'b1 || bus.o_rd_data !== d) begin
        n_err++;
        $display("FAIL full_both_drain: valid=%0b data=%02h, required 1/%02h",
                 bus.o_rd_valid, bus.o_rd_data, d);
      end
    end
  endtask

  task automatic test_underflow();
    step(0, '0, 1, 0, 0);
    n_cmp++;
    if (bus.o_rd_valid !== 1'b0 || bus.o_count !== CW'(0)) begin
      n_err++;
      $display("FAIL underflow_drop: valid=%0b count=%0d, required 0/0", bus.o_rd_valid, bus.o_count);
    end
`ifdef FIFO_SYNC_ERR_EN
    n_cmp++;
    if (bus.o_underflow !== exp_udf) begin
      n_err++;
      $display("FAIL underflow_set: udf=%0b, required %0b", bus.o_underflow, exp_udf);
    end
    step(0, '0, 0, 0, 1);
    n_cmp++;
    if (bus.o_underflow !== exp_udf) begin
      n_err++;
      $display("FAIL underflow_clr: udf=%0b, required %0b", bus.o_underflow, exp_udf);
    end
`endif
    step(0, '0, 0, 0, 0);
  endtask

  task automatic test_empty_both();
    logic [DW-1:0] d;
    step(1, 8'h5A, 1, 0, 0);
    n_cmp++;
    if (bus.o_rd_valid !== 1'b0 || bus.o_count !== CW'(1)) begin
      n_err++;
      $display("FAIL empty_both: valid=%0b count=%0d, required 0/1", bus.o_rd_valid, bus.o_count);
    end
    step(0, '0, 1, 0, 0);
    d = sb_q.pop_front();
    n_cmp++;
    if (bus.o_rd_valid !== 1'b1 || bus.o_rd_data !== d) begin
      n_err++;
      $display("FAIL empty_both_pop: valid=%0b data=%02h, required 1/%02h",
               bus.o_rd_valid, bus.o_rd_data, d);
    end
  endtask

  task automatic test_flush();
    logic [DW-1:0] d;
    for (int i = 0; i < 3; i++) step(1, 8'h21 + 8'(i), 0, 0, 0);
    step(1, 8'h99, 1, 1, 0);
    n_cmp++;
    if ({bus.o_count, bus.o_empty, bus.o_rd_valid} !== {CW'(0), 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL flush: count=%0d empty=%0b valid=%0b, required 0/1/0",
               bus.o_count, bus.o_empty, bus.o_rd_valid);
    end
    step(1, 8'h31, 0, 0, 0);
    step(0, '0, 1, 0, 0);
    d = sb_q.pop_front();
    n_cmp++;
    if (bus.o_rd_valid !== 1'b1 || bus.o_rd_data !== d) begin
      n_err++;
      $display("FAIL flush_after: valid=%0b data=%02h, required 1/%02h",
               bus.o_rd_valid, bus.o_rd_data, d);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] d;
    step(1, 8'h01, 0, 0, 0);
    step(1, 8'h02, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      step(1, 8'($urandom), 1, 0, 0);
      if (exp_valid) begin
        d = sb_q.pop_front();
        n_cmp++;
        if (bus.o_rd_valid !== 1'b1 || bus.o_rd_data !== d) begin
          n_err++;
          $display("FAIL b2b_rd_%0d: valid=%0b data=%02h, required 1/%02h",
                   i, bus.o_rd_valid, bus.o_rd_data, d);
        end
      end
      n_cmp++;
      if (bus.o_count !== CW'(mdl.size())) begin
        n_err++;
        $display("FAIL b2b_count_%0d: count=%0d, required %0d", i, bus.o_count, mdl.size());
      end
    end
    while (mdl.size() > 0) begin
      step(0, '0, 1, 0, 0);
      d = sb_q.pop_front();
      n_cmp++;
      if (bus.o_rd_valid !== 1'b1 || bus.o_rd_data !== d) begin
        n_err++;
        $display("FAIL b2b_drain: valid=%0b data=%02h, required 1/%02h",
                 bus.o_rd_valid, bus.o_rd_data, d);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [DW-1:0] d;
    step(1, 8'h41, 0, 0, 0);
    step(1, 8'h42, 0, 0, 0);
    step(0, '0, 1, 0, 0);
    d = sb_q.pop_front();
    n_cmp++;
    if (bus.o_rd_valid !== 1'b1 || bus.o_rd_data !== d) begin
      n_err++;
      $display("FAIL arst_pre: valid=%0b data=%02h, required 1/%02h",
               bus.o_rd_valid, bus.o_rd_data, d);
    end
    bus.i_rd_en = 0;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.o_count, bus.o_rd_valid, bus.o_rd_data, bus.o_empty} !== {CW'(0), 1'b0, 8'h00, 1'b1}) begin
      n_err++;
      $display("FAIL arst_mid: count=%0d valid=%0b data=%02h empty=%0b, required 0/0/00/1",
               bus.o_count, bus.o_rd_valid, bus.o_rd_data, bus.o_empty);
    end
    mdl.delete(); sb_q.delete();
    exp_valid = 0; exp_hold = '0; exp_ovf = 0; exp_udf = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    step(1, 8'h77, 0, 0, 0);
    step(0, '0, 1, 0, 0);
    d = sb_q.pop_front();
    n_cmp++;
    if (bus.o_rd_valid !== 1'b1 || bus.o_rd_data !== d) begin
      n_err++;
      $display("FAIL arst_recover: valid=%0b data=%02h, required 1/%02h",
               bus.o_rd_valid, bus.o_rd_data, d);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_full_both();
    test_underflow();
    test_empty_both();
    test_flush();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fifo_sync.md
Name: fifo_sync

Overview:
- Parametrised synchronous FIFO with integrated storage; successor to the pointer-only FIFO controller.
- Sits between the UART byte engines (rx deserialiser, tx serialiser) and the host-side register interface.
- Adds arbitrary (non power-of-2) depth, guarded push/pop, occupancy count, programmable almost-full/almost-empty thresholds, registered read data with valid strobe, and synchronous flush.

Parameters:
- DataWidth, 8, data word width in bits.
- Depth, 8, number of entries; any integer >= 2, not restricted to powers of 2.
- AlmostFullThr, 6, o_almost_full asserted when count >= AlmostFullThr (1..Depth).
- AlmostEmptyThr, 2, o_almost_empty asserted when count <= AlmostEmptyThr (0..Depth-1).
- Derived widths: PtrWidth = $clog2(Depth); CntWidth = $clog2(Depth+1).

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  reset, asynchronous assert, active-low.
- i_flush  input  1  synchronous clear of contents.
- i_wr_en  input  1  push request.
- i_wr_data  input  DataWidth  push data.
- i_rd_en  input  1  pop request.
- o_rd_data  output  DataWidth  popped word, registered.
- o_rd_valid  output  1  o_rd_data holds the word popped in the previous cycle.
- o_full  output  1  count == Depth.
- o_empty  output  1  count == 0.
- o_almost_full  output  1  count >= AlmostFullThr.
- o_almost_empty  output  1  count <= AlmostEmptyThr.
- o_count  output  CntWidth  current occupancy.

Behaviour:
- Reset (i_rst_n low, asynchronous): wr_ptr, rd_ptr and count go to 0; o_rd_data = 0; o_rd_valid = 0.
- Reset output values: o_empty = 1, o_full = 0, o_almost_empty = 1, o_almost_full = (AlmostFullThr == 0, never true under legal parameters) = 0.
- Storage array is not reset.
- Push acceptance: push_ok = i_wr_en & !o_full.
  - On push_ok, i_wr_data is written at wr_ptr.
  - wr_ptr advances; it wraps from Depth-1 to 0 by explicit compare, not by bit overflow.
- Pop acceptance: pop_ok = i_rd_en & !o_empty.
  - On pop_ok, mem[rd_ptr] is registered into o_rd_data; o_rd_valid = 1 the next cycle.
  - rd_ptr advances with the same wrap rule.
- Read latency is 1 cycle from an accepted i_rd_en to o_rd_valid/o_rd_data.
- o_rd_valid is a single-cycle strobe per accepted pop. o_rd_data holds its value until the next accepted pop.
- Rejected requests (push when full, pop when empty) are silently dropped. No pointer, count or data change.
- Simultaneous push_ok and pop_ok: both proceed and count is unchanged.
- When full with both requests: the pop proceeds and the push is dropped, because the full flag is evaluated before the pop.
- When empty with both requests: the push proceeds and the pop is dropped.
- Count update: count_next = count + push_ok - pop_ok. It never exceeds Depth and never underflows.
- All status flags are combinational from the registered count. They are valid in the same cycle count changes.
- Flush: i_flush = 1 at a clock edge sets wr_ptr, rd_ptr and count to 0 and o_rd_valid to 0.
  - o_rd_data keeps its last value.
  - Flush overrides any i_wr_en/i_rd_en in the same cycle; those requests are dropped.
- Reset asserted mid-operation aborts everything immediately. A pending o_rd_valid is cleared asynchronously.

Optional Feature:
- Macro: FIFO_SYNC_ERR_EN.
- When defined, adds ports: o_overflow (output 1), o_underflow (output 1), i_err_clr (input 1).
  - o_overflow sets on a cycle with i_wr_en & o_full & !i_flush.
  - o_underflow sets on a cycle with i_rd_en & o_empty & !i_flush.
  - Both flags are sticky until i_err_clr or reset. Set wins over i_err_clr in the same cycle.
  - Flush does not clear them. Reset value is 0.
- When not defined, these ports and flags do not exist; dropped requests are silent.

Test Plan:
- Depth=5, push 0x11..0x15 back-to-back -> o_count 1..5, o_almost_full rises at count 6? no: at count >= 6 never (set AlmostFullThr=4: rises at count 4), o_full=1 at count 5.
- Then pop 5 times -> o_rd_data 0x11..0x15 each one cycle after i_rd_en with o_rd_valid=1; o_empty=1 after the 5th pop. This checks wrap at a non power-of-2 depth.
- Full, push 0xAA with pop asserted -> 0x11 popped, 0xAA not stored, o_count 5->4. With FIFO_SYNC_ERR_EN, o_overflow=1.
- Empty, pop alone -> o_rd_valid stays 0, o_count stays 0. With FIFO_SYNC_ERR_EN, o_underflow=1; i_err_clr=1 -> flag 0 next cycle.
- Count=3, assert i_flush together with i_wr_en -> next cycle o_count=0, o_empty=1; a subsequent push/pop returns the newly pushed word.
- Mid-stream, drive i_rst_n low between clock edges -> o_count, o_rd_valid and o_rd_data go to 0 without a clock edge; o_empty=1.
